// File: rtl/uart_rx_param.sv
// Parametrised UART receiver on the system clock.
// Mid-bit sampling, optional parity, 1 or 2 stop bits, error flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           state_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Synchroniser and edge-detect history
    logic meta_q;
    logic rxs_q;
    logic rxs_prev_q;
    logic fall;

    // Frame state
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;

    // Registered outputs
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            meta_q     <= rx;
            rxs_q      <= meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall = rxs_prev_q & ~rxs_q;

    // State, counters, shifter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    // Next-state: sample at bit centres, publish the word at the last stop centre
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) begin
                    state_d     = START;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // A line back high at mid-start was a glitch
                    state_d = rxs_q ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d       = '0;
                    perr_pend_d = ((^shreg_q) ^ rxs_q) != PAR_ODD;
                    state_d     = STOP;
                end
            end

            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (bit_q == LAST_STOP) begin
                        // Half a bit remains to catch a back-to-back start
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        data_d  = shreg_q;
                        perr_d  = perr_pend_q;
                        ferr_d  = ferr_pend_q | ~rxs_q;
                    end else begin
                        bit_d       = bit_q + 4'd1;
                        ferr_pend_d = ferr_pend_q | ~rxs_q;
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data    = data_q;
    assign rx_done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
    assign state_rx   = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations, frame-level reference model.
// Directed frames with literal expectations plus randomized traffic.
module tb_uart_rx_param;

    localparam int CPB   [4] = '{16, 16, 16, 6};
    localparam int DBITS [4] = '{8, 8, 8, 5};
    localparam int PEN   [4] = '{0, 1, 0, 1};
    localparam int PODD  [4] = '{0, 0, 0, 1};
    localparam int SB    [4] = '{1, 1, 2, 2};

    typedef struct {
        int         dut;
        int         t0;
        int         cyc;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] rxl;
    logic [7:0] rd0, rd1, rd2;
    logic [4:0] rd3;
    logic [3:0] dn, pe, fe, bz;
    logic [2:0] st [4];
    logic [8:0] dat [4];

    int   cyc;
    int   checks;
    int   failures;
    exp_t eq[$];

    logic [8:0] m_data [4];
    logic       m_pe   [4];
    logic       m_fe   [4];
    int         done_cnt  [4];
    int         last_done [4];
    int         prev_done [4];

    uart_rx_param u0 (
        .clk(clk), .rst(rst), .rx(rxl[0]), .rx_data(rd0), .rx_done(dn[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]), .state_rx(st[0])
    );

    uart_rx_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) u1 (
        .clk(clk), .rst(rst), .rx(rxl[1]), .rx_data(rd1), .rx_done(dn[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]), .state_rx(st[1])
    );

    uart_rx_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(2)
    ) u2 (
        .clk(clk), .rst(rst), .rx(rxl[2]), .rx_data(rd2), .rx_done(dn[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]), .state_rx(st[2])
    );

    uart_rx_param #(
        .CLKS_PER_BIT(6), .DATA_BITS(5), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2)
    ) u3 (
        .clk(clk), .rst(rst), .rx(rxl[3]), .rx_data(rd3), .rx_done(dn[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .busy(bz[3]), .state_rx(st[3])
    );

    assign dat[0] = {1'b0, rd0};
    assign dat[1] = {1'b0, rd1};
    assign dat[2] = {1'b0, rd2};
    assign dat[3] = {4'b0, rd3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h",
                     nm, d, cyc, act, exp);
        end
    endtask

    // Clocks from the line's falling edge until rx_done is visible
    function automatic int lat(input int d);
        return 3 + CPB[d] / 2 + (DBITS[d] + PEN[d] + SB[d]) * CPB[d];
    endfunction

    task automatic bitwait(input int d);
        repeat (CPB[d]) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int g);
        rxl[d] = 1'b1;
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame and record what the receiver must report for it
    task automatic send_frame(input int d, input logic [8:0] word,
                              input logic badp, input logic [1:0] stopv,
                              output int t0);
        logic [8:0] mask;
        logic [8:0] w;
        logic       pb;
        logic       ferr;
        mask = 9'((1 << DBITS[d]) - 1);
        w    = word & mask;
        pb   = (^w) ^ (PODD[d] != 0) ^ badp;
        ferr = !stopv[0] || (SB[d] == 2 && !stopv[1]);
        t0   = cyc;
        eq.push_back('{dut: d, t0: t0, cyc: t0 + lat(d), data: w,
                       perr: (PEN[d] != 0) && badp, ferr: ferr});
        rxl[d] = 1'b0;
        bitwait(d);
        for (int i = 0; i < DBITS[d]; i++) begin
            rxl[d] = w[i];
            bitwait(d);
        end
        if (PEN[d] != 0) begin
            rxl[d] = pb;
            bitwait(d);
        end
        for (int s = 0; s < SB[d]; s++) begin
            rxl[d] = stopv[s];
            bitwait(d);
        end
        rxl[d] = 1'b1;
    endtask

    // Per-cycle comparison of every receiver against the model
    initial begin
        logic hit;
        logic inwin;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (rst) begin
                    chk("rst_done", d, 32'(dn[d]), 0);
                    chk("rst_data", d, 32'(dat[d]), 0);
                    chk("rst_flags", d, {30'b0, pe[d], fe[d]}, 0);
                    chk("rst_state", d, {28'b0, bz[d], st[d]}, 0);
                end else begin
                    hit   = 1'b0;
                    inwin = 1'b0;
                    e     = '{default: 0};
                    foreach (eq[i]) begin
                        if (eq[i].dut == d && eq[i].cyc == cyc) begin
                            hit = 1'b1;
                            e   = eq[i];
                        end
                        if (eq[i].dut == d && cyc >= eq[i].t0 + 3 &&
                            cyc < eq[i].cyc)
                            inwin = 1'b1;
                    end
                    chk("rx_done", d, 32'(dn[d]), 32'(hit));
                    if (dn[d]) begin
                        done_cnt[d]++;
                        prev_done[d] = last_done[d];
                        last_done[d] = cyc;
                    end
                    if (hit) begin
                        m_data[d] = e.data;
                        m_pe[d]   = e.perr;
                        m_fe[d]   = e.ferr;
                        chk("idle_at_done", d, {28'b0, bz[d], st[d]}, 0);
                    end
                    if (inwin)
                        chk("busy_in_frame", d, 32'(bz[d]), 1);
                    chk("rx_data", d, 32'(dat[d]), 32'(m_data[d]));
                    chk("parity_err", d, 32'(pe[d]), 32'(m_pe[d]));
                    chk("frame_err", d, 32'(fe[d]), 32'(m_fe[d]));
                end
            end
            for (int i = eq.size() - 1; i >= 0; i--)
                if (eq[i].cyc <= cyc) eq.delete(i);
        end
    end

    initial begin
        int         t0, ta, tb, n0, g;
        logic [8:0] w;
        logic       bp;
        logic [1:0] sv;

        cyc      = 0;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rxl      = 4'hF;
        for (int d = 0; d < 4; d++) begin
            m_data[d]    = '0;
            m_pe[d]      = 1'b0;
            m_fe[d]      = 1'b0;
            done_cnt[d]  = 0;
            last_done[d] = 0;
            prev_done[d] = 0;
        end

        @(negedge clk);
        chk("reset_state", 0, 32'(st[0]), 0);
        chk("reset_data", 0, 32'(dat[0]), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 frame 0xA5 and its latency
        n0 = done_cnt[0];
        send_frame(0, 9'h0A5, 1'b0, 2'b11, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_count", 0, 32'(done_cnt[0] - n0), 1);
        chk("t1_latency", 0, 32'(last_done[0] - t0), 155);
        chk("t1_data", 0, 32'(dat[0]), 32'h0A5);
        chk("t1_flags", 0, {30'b0, pe[0], fe[0]}, 0);

        // Short low glitch is rejected
        n0 = done_cnt[0];
        rxl[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxl[0] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t2_state", 0, {28'b0, bz[0], st[0]}, 0);
        chk("t2_nodone", 0, 32'(done_cnt[0] - n0), 0);
        chk("t2_data", 0, 32'(dat[0]), 32'h0A5);

        // Back-to-back frames, no idle gap
        n0 = done_cnt[0];
        send_frame(0, 9'h055, 1'b0, 2'b11, ta);
        send_frame(0, 9'h0AA, 1'b0, 2'b11, tb);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_count", 0, 32'(done_cnt[0] - n0), 2);
        chk("t5_spacing", 0, 32'(last_done[0] - prev_done[0]), 160);
        chk("t5_data", 0, 32'(dat[0]), 32'h0AA);

        // Reset in the 4th data bit drops the frame
        n0 = done_cnt[0];
        rxl[0] = 1'b0;
        bitwait(0);
        rxl[0] = 1'b1;
        repeat (16 * 3 + 8) @(posedge clk);
        #3;
        chk("t6_in_data", 0, {28'b0, bz[0], st[0]}, 32'h0A);
        rst = 1'b1;
        eq.delete();
        for (int d = 0; d < 4; d++) begin
            m_data[d] = '0;
            m_pe[d]   = 1'b0;
            m_fe[d]   = 1'b0;
        end
        #1;
        chk("t6_rst_data", 0, 32'(dat[0]), 0);
        chk("t6_rst_state", 0, {28'b0, bz[0], st[0]}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_nodone", 0, 32'(done_cnt[0] - n0), 0);
        send_frame(0, 9'h07E, 1'b0, 2'b11, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_data", 0, 32'(dat[0]), 32'h07E);
        chk("t6_count", 0, 32'(done_cnt[0] - n0), 1);

        // Long break: one errored frame, then silence until the line rises
        n0 = done_cnt[0];
        t0 = cyc;
        eq.push_back('{dut: 0, t0: t0, cyc: t0 + lat(0), data: 9'h000,
                       perr: 1'b0, ferr: 1'b1});
        rxl[0] = 1'b0;
        repeat (30) bitwait(0);
        chk("brk_count", 0, 32'(done_cnt[0] - n0), 1);
        chk("brk_data", 0, 32'(dat[0]), 0);
        chk("brk_ferr", 0, 32'(fe[0]), 1);
        chk("brk_idle", 0, 32'(st[0]), 0);
        idle(0, 48);

        // Even parity
        send_frame(1, 9'h003, 1'b1, 2'b11, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_perr1", 1, 32'(pe[1]), 1);
        chk("t3_data1", 1, 32'(dat[1]), 32'h003);
        send_frame(1, 9'h003, 1'b0, 2'b11, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_perr0", 1, 32'(pe[1]), 0);

        // Two stop bits: bad second stop, then a 10-bit break
        send_frame(2, 9'h03C, 1'b0, 2'b01, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_ferr", 2, 32'(fe[2]), 1);
        chk("t4_data", 2, 32'(dat[2]), 32'h03C);
        n0 = done_cnt[2];
        send_frame(2, 9'h000, 1'b0, 2'b10, t0);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_brk_ferr", 2, 32'(fe[2]), 1);
        chk("t4_brk_data", 2, 32'(dat[2]), 0);
        chk("t4_brk_count", 2, 32'(done_cnt[2] - n0), 1);

        // Randomized traffic on every configuration
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 15; k++) begin
                w  = 9'($urandom);
                bp = (PEN[d] != 0) && ($urandom_range(0, 3) == 0);
                sv = 2'b11;
                if ($urandom_range(0, 4) == 0) sv[0] = 1'b0;
                if ($urandom_range(0, 4) == 0) sv[1] = 1'b0;
                send_frame(d, w, bp, sv, t0);
                if (!sv[SB[d] - 1])
                    g = $urandom_range(2, 30);
                else if ($urandom_range(0, 2) == 0)
                    g = 0;
                else
                    g = $urandom_range(1, 30);
                idle(d, g);
            end
            idle(d, 20);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("pending_frames", 0, 32'(eq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
